// File: rtl/fir_axis_serial_pkg.sv
// rtl/fir_axis_serial_pkg.sv - shared widths, FSM encoding and helpers for the serial FIR
package fir_axis_serial_pkg;

    localparam int SAMPLE_W = 16;
    localparam int COEF_W   = 16;
    localparam int PROD_W   = SAMPLE_W + COEF_W;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MAC  = 2'd1,
        ST_OUT  = 2'd2
    } fir_state_e;

    function automatic int fir_clog2(input int n);
        int r;
        r = 0;
        for (int k = 0; k < 32; k++) begin
            if ((1 << r) < n) begin
                r = r + 1;
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/fir_coef_rom.sv
// rtl/fir_coef_rom.sv - combinational coefficient ROM indexed by tap number
module fir_coef_rom
    import fir_axis_serial_pkg::*;
#(
    parameter int                      NTAPS = 16,
    parameter logic [NTAPS*COEF_W-1:0] COEFS = '0
) (
    input  logic [fir_clog2(NTAPS)-1:0] addr,
    output logic [COEF_W-1:0]           coef
);

    // Tap k lives at bits [k*COEF_W +: COEF_W]; unused addresses read as zero.
    always_comb begin
        coef = '0;
        if (int'(addr) < NTAPS) begin
            coef = COEFS[int'(addr)*COEF_W +: COEF_W];
        end
    end

endmodule

// File: rtl/fir_axis_serial.sv
// rtl/fir_axis_serial.sv - serial-MAC FIR with stream input/output and round/saturate
module fir_axis_serial
    import fir_axis_serial_pkg::*;
#(
    parameter int                      NTAPS = 16,
    parameter logic [NTAPS*COEF_W-1:0] COEFS = {{((NTAPS-1)*COEF_W){1'b0}}, 16'h7FFF},
    parameter int                      SHIFT = 15,
    parameter int                      OW    = 16
) (
    input  logic                clk,
    input  logic                resetn,
    input  logic                s_tvalid,
    output logic                s_tready,
    input  logic [SAMPLE_W-1:0] s_tdata,
    output logic                m_tvalid,
    input  logic                m_tready,
    output logic [OW-1:0]       m_tdata
);

    localparam int AW   = fir_clog2(NTAPS);
    localparam int ACCW = PROD_W + AW;
    localparam int RW   = ACCW + 1;
    localparam logic signed [RW-1:0] RND    = RW'((64'd1 << SHIFT) >> 1);
    localparam logic signed [RW-1:0] SAT_HI = RW'((64'd1 << (OW-1)) - 64'd1);
    localparam logic signed [RW-1:0] SAT_LO = ~SAT_HI;

    fir_state_e                 state_q, state_d;
    logic signed [SAMPLE_W-1:0] x_q [NTAPS];
    logic signed [ACCW-1:0]     acc_q, acc_d;
    logic [AW-1:0]              idx_q, idx_d;
    logic                       s_tready_q, s_tready_d;
    logic                       m_tvalid_q, m_tvalid_d;
    logic [OW-1:0]              m_tdata_q, m_tdata_d;

    logic [COEF_W-1:0]          coef;
    logic signed [PROD_W-1:0]   prod;
    logic signed [ACCW-1:0]     acc_sum;
    logic signed [RW-1:0]       rounded;
    logic [OW-1:0]              sat;
    logic                       accept;
    logic                       last_tap;
    logic                       shift_en;

    fir_coef_rom #(
        .NTAPS (NTAPS),
        .COEFS (COEFS)
    ) u_rom (
        .addr (idx_q),
        .coef (coef)
    );

    assign accept   = s_tvalid && s_tready_q;
    assign last_tap = (idx_q == AW'(NTAPS - 1));
    assign prod     = PROD_W'(x_q[idx_q]) * PROD_W'($signed(coef));
    assign acc_sum  = acc_q + ACCW'(prod);
    // One extra bit keeps the rounding constant from overflowing the accumulator range.
    assign rounded  = (RW'(acc_sum) + RND) >>> SHIFT;

    always_comb begin
        sat = rounded[OW-1:0];
        if (rounded > SAT_HI) begin
            sat = SAT_HI[OW-1:0];
        end else if (rounded < SAT_LO) begin
            sat = SAT_LO[OW-1:0];
        end
    end

    always_comb begin
        state_d    = state_q;
        acc_d      = acc_q;
        idx_d      = idx_q;
        s_tready_d = s_tready_q;
        m_tvalid_d = m_tvalid_q;
        m_tdata_d  = m_tdata_q;
        shift_en   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                s_tready_d = 1'b1;
                if (accept) begin
                    shift_en   = 1'b1;
                    acc_d      = '0;
                    idx_d      = '0;
                    s_tready_d = 1'b0;
                    state_d    = ST_MAC;
                end
            end
            ST_MAC: begin
                acc_d = acc_sum;
                idx_d = idx_q + 1'b1;
                if (last_tap) begin
                    idx_d      = '0;
                    m_tvalid_d = 1'b1;
                    m_tdata_d  = sat;
                    state_d    = ST_OUT;
                end
            end
            ST_OUT: begin
                if (m_tready) begin
                    m_tvalid_d = 1'b0;
                    s_tready_d = 1'b1;
                    state_d    = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q    <= ST_IDLE;
            acc_q      <= '0;
            idx_q      <= '0;
            s_tready_q <= 1'b0;
            m_tvalid_q <= 1'b0;
            m_tdata_q  <= '0;
        end else begin
            state_q    <= state_d;
            acc_q      <= acc_d;
            idx_q      <= idx_d;
            s_tready_q <= s_tready_d;
            m_tvalid_q <= m_tvalid_d;
            m_tdata_q  <= m_tdata_d;
        end
    end

    // Delay line history survives between samples; only reset clears it.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            for (int k = 0; k < NTAPS; k++) begin
                x_q[k] <= '0;
            end
        end else if (shift_en) begin
            x_q[0] <= s_tdata;
            for (int k = 1; k < NTAPS; k++) begin
                x_q[k] <= x_q[k-1];
            end
        end
    end

    assign s_tready = s_tready_q;
    assign m_tvalid = m_tvalid_q;
    assign m_tdata  = m_tdata_q;

endmodule

// File: tb/tb_fir_axis_serial.sv
// tb/tb_fir_axis_serial.sv - self-checking bench for fir_axis_serial across four configurations
module tb_fir_axis_serial;

    logic clk = 1'b0;
    logic resetn;
    always #5 clk = ~clk;

    function automatic logic [255:0] ramp_coefs();
        logic [255:0] r;
        r = '0;
        for (int k = 0; k < 16; k++) begin
            r[k*16 +: 16] = 16'(k + 1);
        end
        return r;
    endfunction

    localparam logic [255:0] C0 = ramp_coefs();
    localparam logic [255:0] C1 = {16{16'h7FFF}};
    localparam logic [31:0]  C2 = {16'h0000, 16'h4000};
    localparam logic [79:0]  C3 = {16'h0F0F, 16'hF00D, 16'h1234, 16'h8000, 16'h7FFF};

    int ntaps [4] = '{16, 16, 2, 5};
    int shft  [4] = '{0, 15, 15, 12};
    int ow    [4] = '{32, 16, 16, 18};
    int coef_m [4][16];
    int hist   [4][16];

    logic        s_tvalid_r [4];
    logic [15:0] s_tdata_r  [4];
    logic        m_tready_r [4];
    logic        s_tready   [4];
    logic        m_tvalid   [4];
    logic [31:0] m_data     [4];
    logic [31:0] m_tdata0;
    logic [15:0] m_tdata1;
    logic [15:0] m_tdata2;
    logic [17:0] m_tdata3;

    assign m_data[0] = m_tdata0;
    assign m_data[1] = {{16{m_tdata1[15]}}, m_tdata1};
    assign m_data[2] = {{16{m_tdata2[15]}}, m_tdata2};
    assign m_data[3] = {{14{m_tdata3[17]}}, m_tdata3};

    fir_axis_serial #(.NTAPS(16), .COEFS(C0), .SHIFT(0), .OW(32)) u_dut0 (
        .clk(clk), .resetn(resetn), .s_tvalid(s_tvalid_r[0]), .s_tready(s_tready[0]),
        .s_tdata(s_tdata_r[0]), .m_tvalid(m_tvalid[0]), .m_tready(m_tready_r[0]), .m_tdata(m_tdata0));
    fir_axis_serial #(.NTAPS(16), .COEFS(C1), .SHIFT(15), .OW(16)) u_dut1 (
        .clk(clk), .resetn(resetn), .s_tvalid(s_tvalid_r[1]), .s_tready(s_tready[1]),
        .s_tdata(s_tdata_r[1]), .m_tvalid(m_tvalid[1]), .m_tready(m_tready_r[1]), .m_tdata(m_tdata1));
    fir_axis_serial #(.NTAPS(2), .COEFS(C2), .SHIFT(15), .OW(16)) u_dut2 (
        .clk(clk), .resetn(resetn), .s_tvalid(s_tvalid_r[2]), .s_tready(s_tready[2]),
        .s_tdata(s_tdata_r[2]), .m_tvalid(m_tvalid[2]), .m_tready(m_tready_r[2]), .m_tdata(m_tdata2));
    fir_axis_serial #(.NTAPS(5), .COEFS(C3), .SHIFT(12), .OW(18)) u_dut3 (
        .clk(clk), .resetn(resetn), .s_tvalid(s_tvalid_r[3]), .s_tready(s_tready[3]),
        .s_tdata(s_tdata_r[3]), .m_tvalid(m_tvalid[3]), .m_tready(m_tready_r[3]), .m_tdata(m_tdata3));

    int n_checks = 0;
    int n_errors = 0;

    task automatic check_val(input string tag, input longint obs, input longint exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Filter output straight from the definition: dot product, round half up, clamp.
    function automatic longint model_out(input int i);
        longint acc, r, hi, lo;
        acc = 0;
        for (int k = 0; k < ntaps[i]; k++) begin
            acc += longint'(hist[i][k]) * longint'(coef_m[i][k]);
        end
        r  = (acc + ((longint'(1) << shft[i]) >>> 1)) >>> shft[i];
        hi = (longint'(1) << (ow[i] - 1)) - 1;
        lo = -hi - 1;
        if (r > hi) r = hi;
        if (r < lo) r = lo;
        return r;
    endfunction

    function automatic logic [15:0] rand_sample();
        case ($urandom_range(0, 7))
            0:       return 16'h7FFF;
            1:       return 16'h8000;
            2:       return 16'h0000;
            default: return 16'($urandom);
        endcase
    endfunction

    int     cyc = 0;
    bit     pend      [4];
    longint exp_v     [4];
    int     acc_cyc   [4];
    int     last_acc  [4];
    bit     last_thru [4];
    bit     thru_chk  [4];
    bit     prev_mv   [4];
    bit     prev_mr   [4];
    logic [31:0] prev_d [4];
    bit     post_hs   [4];

    initial begin
        forever begin
            @(negedge clk);
            cyc++;
            if (!resetn) begin
                for (int i = 0; i < 4; i++) begin
                    pend[i] = 0; prev_mv[i] = 0; prev_mr[i] = 0; post_hs[i] = 0; last_thru[i] = 0;
                    for (int k = 0; k < 16; k++) hist[i][k] = 0;
                end
            end else begin
                for (int i = 0; i < 4; i++) begin
                    if (post_hs[i]) begin
                        check_val($sformatf("idle_ready[%0d]", i), s_tready[i], 1);
                        check_val($sformatf("idle_valid[%0d]", i), m_tvalid[i], 0);
                        post_hs[i] = 0;
                    end
                    if (prev_mv[i] && !prev_mr[i]) begin
                        check_val($sformatf("valid_held[%0d]", i), m_tvalid[i], 1);
                        check_val($sformatf("data_stable[%0d]", i), m_data[i], prev_d[i]);
                        check_val($sformatf("busy_ready[%0d]", i), s_tready[i], 0);
                    end
                    if (m_tvalid[i] && !prev_mv[i]) begin
                        check_val($sformatf("latency[%0d]", i), cyc - acc_cyc[i], ntaps[i] + 1);
                    end
                    if (s_tvalid_r[i] && s_tready[i]) begin
                        check_val($sformatf("accept_busy[%0d]", i), pend[i], 0);
                        if (thru_chk[i] && last_thru[i]) begin
                            check_val($sformatf("spacing[%0d]", i), cyc - last_acc[i], ntaps[i] + 2);
                        end
                        last_thru[i] = thru_chk[i];
                        last_acc[i]  = cyc;
                        for (int k = ntaps[i] - 1; k > 0; k--) hist[i][k] = hist[i][k-1];
                        hist[i][0] = int'($signed(s_tdata_r[i]));
                        exp_v[i]   = model_out(i);
                        pend[i]    = 1;
                        acc_cyc[i] = cyc;
                    end
                    if (m_tvalid[i] && m_tready_r[i]) begin
                        check_val($sformatf("out_pending[%0d]", i), pend[i], 1);
                        check_val($sformatf("data[%0d]", i), longint'($signed(m_data[i])), exp_v[i]);
                        pend[i]    = 0;
                        post_hs[i] = 1;
                    end
                    prev_mv[i] = m_tvalid[i];
                    prev_mr[i] = m_tready_r[i];
                    prev_d[i]  = m_data[i];
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic xfer(input int i, input logic [15:0] smp, input int stall, output longint got);
        int n;
        s_tvalid_r[i] = 1'b1;
        s_tdata_r[i]  = smp;
        n = 0;
        while (!s_tready[i] && n < 50) begin tick(); n++; end
        check_val("accept_wait", n < 50, 1);
        tick();
        s_tvalid_r[i] = 1'b0;
        s_tdata_r[i]  = 16'($urandom);
        n = 0;
        while (!m_tvalid[i] && n < 100) begin tick(); n++; end
        check_val("result_wait", n < 100, 1);
        repeat (stall) tick();
        got = longint'($signed(m_data[i]));
        m_tready_r[i] = 1'b1;
        tick();
        m_tready_r[i] = 1'b0;
    endtask

    task automatic drain(input int i);
        int  n;
        bit  hs;
        n = 0;
        while ((s_tvalid_r[i] || pend[i]) && n < 200) begin
            m_tready_r[i] = 1'b1;
            hs = s_tvalid_r[i] && s_tready[i];
            tick();
            if (hs) s_tvalid_r[i] = 1'b0;
            n++;
        end
        check_val($sformatf("drain[%0d]", i), n < 200, 1);
        m_tready_r[i] = 1'b0;
    endtask

    task automatic run_random(input int i, input int ncyc);
        bit hs;
        for (int c = 0; c < ncyc; c++) begin
            if (!s_tvalid_r[i] && $urandom_range(0, 99) < 60) begin
                s_tvalid_r[i] = 1'b1;
                s_tdata_r[i]  = rand_sample();
            end
            m_tready_r[i] = ($urandom_range(0, 99) < 50);
            hs = s_tvalid_r[i] && s_tready[i];
            tick();
            if (hs) s_tvalid_r[i] = 1'b0;
        end
        drain(i);
    endtask

    task automatic run_thru(input int i, input int nacc);
        int got_n;
        int n;
        bit hs;
        got_n = 0;
        n = 0;
        thru_chk[i]   = 1'b1;
        m_tready_r[i] = 1'b1;
        s_tvalid_r[i] = 1'b1;
        s_tdata_r[i]  = rand_sample();
        while (got_n < nacc && n < 500) begin
            hs = s_tready[i];
            tick();
            n++;
            if (hs) begin
                got_n++;
                s_tdata_r[i] = rand_sample();
            end
        end
        s_tvalid_r[i] = 1'b0;
        check_val("thru_accepts", got_n, nacc);
        drain(i);
        thru_chk[i] = 1'b0;
    endtask

    logic [15:0] rnd_in  [8] = '{16'h0001, 16'hFFFF, 16'h0003, 16'hFFFD, 16'h0002, 16'h7FFF, 16'h8000, 16'h0000};
    longint      rnd_exp [8] = '{1, 0, 2, -1, 1, 16384, -16384, 0};

    task automatic impulse(input string tag);
        longint got;
        for (int k = 0; k <= 16; k++) begin
            xfer(0, (k == 0) ? 16'd1 : 16'd0, 0, got);
            check_val($sformatf("%s_%0d", tag, k), got, (k < 16) ? longint'(k + 1) : 0);
        end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        longint got;
        for (int k = 0; k < 16; k++) begin
            coef_m[0][k] = k + 1;
            coef_m[1][k] = 32767;
            coef_m[2][k] = 0;
            coef_m[3][k] = 0;
        end
        coef_m[2][0] = 16384;
        coef_m[3][0] = 32767;
        coef_m[3][1] = -32768;
        coef_m[3][2] = 4660;
        coef_m[3][3] = -4083;
        coef_m[3][4] = 3855;
        resetn = 1'b0;
        for (int i = 0; i < 4; i++) begin
            s_tvalid_r[i] = 1'b0;
            s_tdata_r[i]  = '0;
            m_tready_r[i] = 1'b0;
        end
        repeat (3) @(posedge clk);
        #1;
        for (int i = 0; i < 4; i++) begin
            check_val($sformatf("rst_ready[%0d]", i), s_tready[i], 0);
            check_val($sformatf("rst_valid[%0d]", i), m_tvalid[i], 0);
            check_val($sformatf("rst_data[%0d]", i), m_data[i], 0);
        end
        resetn = 1'b1;
        check_val("ready_before_edge", s_tready[0], 0);
        tick();
        for (int i = 0; i < 4; i++) check_val($sformatf("ready_after_release[%0d]", i), s_tready[i], 1);

        impulse("impulse");

        for (int k = 0; k < 16; k++) xfer(1, 16'h7FFF, 0, got);
        check_val("sat_pos", got, 32767);
        for (int k = 0; k < 16; k++) xfer(1, 16'h8000, 0, got);
        check_val("sat_neg", got, -32768);

        for (int k = 0; k < 8; k++) begin
            xfer(2, rnd_in[k], 0, got);
            check_val($sformatf("round_%0d", k), got, rnd_exp[k]);
        end

        for (int k = 0; k < 6; k++) begin
            xfer(3, rand_sample(), 5, got);
            check_val($sformatf("bp_%0d", k), got, exp_v[3]);
        end

        run_thru(0, 4);
        for (int i = 0; i < 4; i++) run_random(i, 400);

        s_tvalid_r[0] = 1'b1;
        s_tdata_r[0]  = 16'd1;
        check_val("mac_rst_pre_ready", s_tready[0], 1);
        tick();
        s_tvalid_r[0] = 1'b0;
        repeat (7) tick();
        #2;
        resetn = 1'b0;
        #1;
        check_val("mac_rst_valid", m_tvalid[0], 0);
        check_val("mac_rst_ready", s_tready[0], 0);
        @(posedge clk);
        #1;
        resetn = 1'b1;
        tick();
        check_val("mac_rst_ready_back", s_tready[0], 1);
        impulse("impulse_after_rst");

        for (int i = 0; i < 4; i++) check_val($sformatf("final_pending[%0d]", i), pend[i], 0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
